// File: rtl/rs_conv_pkg.sv
// rs_conv_pkg: shared state encoding and accumulator width helper for rs_conv_array
package rs_conv_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_F, LOAD_I, MAC, SUM, DRAIN} rs_state_e;
  function automatic int acc_width(input int dw, input int k);
    return 2 * dw + $clog2(k * k);
  endfunction
endpackage

// File: rtl/rs_conv_array_pe_row.sv
// rs_pe_row: one row-stationary PE holding E partial sums for a single filter row
module rs_pe_row
  import rs_conv_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int K = 3,
  parameter int N = 7,
  localparam int E = N - K + 1,
  localparam int ACC_W = acc_width(DATA_W, K),
  localparam int KI = (K > 1) ? $clog2(K) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic [KI-1:0]            tap,
  input  logic signed [DATA_W-1:0] filt_row [K],
  input  logic signed [DATA_W-1:0] map_row [N],
  output logic signed [ACC_W-1:0]  psum [E]
);
  logic signed [DATA_W-1:0]   f;
  logic signed [DATA_W-1:0]   m [E];
  logic signed [2*DATA_W-1:0] p [E];
  // select this tap's filter weight and the shifted map window, then form products
  always_comb begin
    f = '0;
    for (int x = 0; x < E; x++) m[x] = '0;
    for (int t = 0; t < K; t++)
      if (tap == KI'(t)) begin
        f = filt_row[t];
        for (int x = 0; x < E; x++) m[x] = map_row[x + t];
      end
    for (int x = 0; x < E; x++) p[x] = f * m[x];
  end
  // accumulate one tap per cycle into every output column
  always_ff @(posedge clk)
    for (int x = 0; x < E; x++)
      if (rst || clr) psum[x] <= '0;
      else if (en) psum[x] <= psum[x] + ACC_W'(p[x]);
endmodule

// File: rtl/rs_conv_array.sv
// rs_conv_array: KxK-filter valid convolution over an NxN map on a KxE row PE grid (RS_CONV_RELU_EN clamps negative results)
module rs_conv_array
  import rs_conv_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int K = 3,
  parameter int N = 7,
  localparam int ACC_W = acc_width(DATA_W, K)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              busy,
  output logic              done
);
  localparam int E = N - K + 1;
  localparam int CW = $clog2(N + 1);
  localparam int KI = (K > 1) ? $clog2(K) : 1;
  localparam int NI = (N > 1) ? $clog2(N) : 1;
  localparam int EI = (E > 1) ? $clog2(E) : 1;
  rs_state_e state, state_n;
  logic [CW-1:0] lr, lc, lim;
  logic step, wrap, last;
  logic signed [DATA_W-1:0] filt [K][K];
  logic signed [DATA_W-1:0] map [N][N];
  logic signed [ACC_W-1:0] psum [K][E][E];
  logic signed [ACC_W-1:0] sum [E][E];
  logic signed [ACC_W-1:0] res [E][E];
  logic signed [ACC_W-1:0] r;
  assign in_ready = state == LOAD_F || state == LOAD_I;
  assign out_valid = state == DRAIN;
  assign busy = state != IDLE;
  assign lim = state == LOAD_I ? CW'(N) : state == DRAIN ? CW'(E) : CW'(K);
  assign step = state == MAC || (in_valid && in_ready) || (out_valid && out_ready);
  assign wrap = lc == lim - 1'b1;
  assign last = wrap && (state == MAC || lr == lim - 1'b1);
  assign done = out_valid && step && last;
  assign r = res[lr[EI-1:0]][lc[EI-1:0]];
`ifdef RS_CONV_RELU_EN
  assign out_data = (out_valid && !r[ACC_W-1]) ? r : '0;
`else
  assign out_data = out_valid ? r : '0;
`endif
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // phase sequencing: loads and drain end on their last handshake, MAC after K taps
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? LOAD_F : IDLE;
      LOAD_F:  state_n = (step && last) ? LOAD_I : LOAD_F;
      LOAD_I:  state_n = (step && last) ? MAC : LOAD_I;
      MAC:     state_n = last ? SUM : MAC;
      SUM:     state_n = DRAIN;
      DRAIN:   state_n = (step && last) ? IDLE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  // row/column counters shared by load, tap and drain phases; cleared on every phase change
  always_ff @(posedge clk)
    if (rst || state_n != state) begin
      lr <= '0;
      lc <= '0;
    end else if (step) begin
      lc <= wrap ? '0 : lc + 1'b1;
      if (wrap) lr <= (lr == lim - 1'b1) ? '0 : lr + 1'b1;
    end
  // operand buffers and result capture
  always_ff @(posedge clk) begin
    if (state == LOAD_F && step) filt[lr[KI-1:0]][lc[KI-1:0]] <= in_data;
    if (state == LOAD_I && step) map[lr[NI-1:0]][lc[NI-1:0]] <= in_data;
    if (state == SUM) res <= sum;
  end
  // vertical psum chain: add the K row contributions for each output
  always_comb
    for (int j = 0; j < E; j++)
      for (int x = 0; x < E; x++) begin
        sum[j][x] = '0;
        for (int i = 0; i < K; i++) sum[j][x] = sum[j][x] + psum[i][j][x];
      end
  for (genvar i = 0; i < K; i++) begin : g_row
    for (genvar j = 0; j < E; j++) begin : g_col
      rs_pe_row #(.DATA_W(DATA_W), .K(K), .N(N)) u_pe (
        .clk(clk),
        .rst(rst),
        .clr(state == LOAD_I && state_n == MAC),
        .en(state == MAC),
        .tap(lc[KI-1:0]),
        .filt_row(filt[i]),
        .map_row(map[i+j]),
        .psum(psum[i][j])
      );
    end
  end
endmodule

// File: tb/tb_rs_conv_array.sv
// tb_rs_conv_array: directed and randomized job checks for rs_conv_array (K=3, N=7)
module tb_rs_conv_array;
  localparam int K = 3, N = 7, E = 5, AW = 36;
  logic clk = 0, rst = 1, start = 0, in_valid = 0, out_ready = 0;
  logic [15:0] in_data = '0;
  logic in_ready, out_valid, busy, done;
  logic [AW-1:0] out_data;
  int tests = 0, fails = 0, cyc = 0, dn = 0, t;
  logic signed [15:0] f [K*K];
  logic signed [15:0] m [N*N];
  longint ex [E*E];

  rs_conv_array #(.DATA_W(16), .K(K), .N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) if (done) dn++;

  task automatic check(input string tag, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic load(input int nmap, input bit gaps, input bit glitch, output int tl);
    int n;
    tl = cyc;
    start = 1;
    @(negedge clk);
    start = 0;
    check("busy_rise", busy, 1);
    check("ready_rise", in_ready, 1);
    for (int k = 0; k < K*K + nmap; k++) begin
      if (gaps) begin
        in_valid = 0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      in_valid = 1;
      in_data = k < K*K ? f[k] : m[k-K*K];
      start = glitch && k == 20;
      n = 0;
      while (!in_ready && n < 20) begin @(negedge clk); n++; end
      if (!in_ready) check("in_ready_timeout", 0, 1);
      tl = cyc;
      @(negedge clk);
    end
    in_valid = 0;
    start = 0;
    if (nmap == N*N) check("ready_drop", in_ready, 0);
  endtask

  task automatic drain(input int tl, input int nw, input bit bp, input bit glitch);
    int n, d0;
    bit held, seen;
    logic [AW-1:0] hv;
    d0 = dn; n = 0; held = 0; seen = 0; hv = '0;
    for (int w = 0; w < nw; w++) begin
      forever begin
        out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        start = glitch && w == 3;
        #1;
        if (held) check("valid_hold", out_valid, 1);
        if (out_valid) begin
          if (!seen) begin seen = 1; check("first_valid_lat", cyc - tl, K + 2); end
          if (held) check($sformatf("stable%0d", w), out_data, hv);
          if (out_ready) begin
            check($sformatf("res%0d", w), $signed(out_data), ex[w]);
            check($sformatf("done%0d", w), done, w == E*E - 1);
            held = 0;
            @(negedge clk);
            break;
          end
          held = 1;
          hv = out_data;
        end
        @(negedge clk);
        n++;
        if (n > 300) begin
          check("out_timeout", 0, 1);
          start = 0;
          return;
        end
      end
    end
    start = 0;
    if (nw == E*E) begin
      check("end_busy", busy, 0);
      check("end_done", done, 0);
      check("end_valid", out_valid, 0);
      check("done_count", dn - d0, 1);
    end
  endtask

  task automatic model();
    longint s;
    for (int j = 0; j < E; j++)
      for (int x = 0; x < E; x++) begin
        s = 0;
        for (int i = 0; i < K; i++)
          for (int u = 0; u < K; u++)
            s += longint'(f[i*K+u]) * longint'(m[(i+j)*N+x+u]);
`ifdef RS_CONV_RELU_EN
        if (s < 0) s = 0;
`endif
        ex[j*E+x] = s;
      end
  endtask

  task automatic set_identity();
    foreach (f[k]) f[k] = (k == 4) ? 16'sd1 : 16'sd0;
    foreach (m[k]) m[k] = 16'(k);
    for (int j = 0; j < E; j++)
      for (int x = 0; x < E; x++) ex[j*E+x] = (j + 1) * 7 + x + 1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 0;
    @(negedge clk);

    foreach (f[k]) f[k] = 1;
    foreach (m[k]) m[k] = 1;
    foreach (ex[k]) ex[k] = 9;
    load(N*N, 0, 0, t);
    drain(t, E*E, 0, 0);

    set_identity();
    load(N*N, 0, 0, t);
    drain(t, E*E, 0, 0);

    foreach (f[k]) f[k] = -1;
    foreach (m[k]) m[k] = 2;
`ifdef RS_CONV_RELU_EN
    foreach (ex[k]) ex[k] = 0;
`else
    foreach (ex[k]) ex[k] = -18;
`endif
    load(N*N, 0, 0, t);
    drain(t, E*E, 1, 0);

    for (int r = 0; r < 2; r++) begin
      foreach (f[k]) f[k] = 16'($urandom);
      foreach (m[k]) m[k] = 16'($urandom);
      model();
      load(N*N, 1, 1, t);
      drain(t, E*E, 1, 1);
    end

    load(10, 0, 0, t);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check_idle("rst_load");
    @(negedge clk);

    set_identity();
    load(N*N, 0, 0, t);
    drain(t, 10, 0, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check_idle("rst_drain");
    @(negedge clk);

    load(N*N, 1, 0, t);
    drain(t, E*E, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=%0d exp=0", cyc);
    $fatal(1);
  end
endmodule
